// File: rtl/memory_pkg.sv
// memory_pkg: shared access-type and responder-state enums plus the alignment rule.
package memory_pkg;

    typedef enum logic [1:0] {
        MEM_READ = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } rsp_state_e;

    // Halves need an even address, words need a word-aligned one.
    function automatic logic is_misaligned(input mem_type_e t, input logic [1:0] off);
        return (t == MEM_HALF && off[0]) || (t == MEM_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/memory_responder_store_merge.sv
// store_merge: merges store data into the addressed byte/half lanes of an old word.
// Ports: old_i (current word), wdata_i (right-aligned store data), type_i (access type),
//        off_i (addr[1:0]), merged_o (word with the store applied; old_i for reads).
module store_merge
    import memory_pkg::*;
#(
    parameter int RegBits = 32
) (
    input  logic [RegBits-1:0] old_i,
    input  logic [RegBits-1:0] wdata_i,
    input  mem_type_e          type_i,
    input  logic [1:0]         off_i,
    output logic [RegBits-1:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        unique case (type_i)
            MEM_BYTE: merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            MEM_HALF: merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            MEM_WORD: merged_o = wdata_i;
            default:  merged_o = old_i;
        endcase
    end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: single-port word memory behind a valid/ready request/response handshake
// with a fixed number of wait states.
// Ports: clk_i/rst_i (clock, sync active-high reset); req_valid_i/req_ready_o, addr_i, wdata_i,
//        we_i (request side); rsp_valid_o/rsp_ready_i, rdata_o, err_o (response side).
module memory_responder
    import memory_pkg::*;
#(
    parameter int RegBits    = 32,
    parameter int DepthWords = 256,
    parameter int WaitCycles = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [RegBits-1:0] addr_i,
    input  logic [RegBits-1:0] wdata_i,
    input  logic [1:0]         we_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [RegBits-1:0] rdata_o,
    output logic               err_o
);

    localparam int IdxBits = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam logic [RegBits-3:0] DepthLim = (RegBits-2)'(DepthWords);

    rsp_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [RegBits-1:0] addr_q, wdata_q, rdata_q;
    logic [1:0]         we_q;
    logic               err_q;
    logic [RegBits-1:0] mem [DepthWords];

    logic               accept, enter_resp, misaligned, out_of_range, commit;
    logic [RegBits-1:0] cur_addr, cur_wdata, old_word, merged;
    mem_type_e          cur_type;
    logic [IdxBits-1:0] idx;

    assign accept     = state_q == ST_IDLE && req_valid_i;
    assign enter_resp = (accept && WaitCycles == 0) || (state_q == ST_WAIT && cnt_q == 4'd0);

    // With zero wait states the commit edge is the accept edge, so the live inputs are used.
    assign cur_addr  = state_q == ST_IDLE ? addr_i  : addr_q;
    assign cur_wdata = state_q == ST_IDLE ? wdata_i : wdata_q;
    assign cur_type  = mem_type_e'(state_q == ST_IDLE ? we_i : we_q);

    assign misaligned   = is_misaligned(cur_type, cur_addr[1:0]);
    assign out_of_range = cur_addr[RegBits-1:2] >= DepthLim;
    assign idx          = cur_addr[IdxBits+1:2];
    assign old_word     = out_of_range ? '0 : mem[idx];
    assign commit       = enter_resp && cur_type != MEM_READ && !misaligned && !out_of_range;

    store_merge #(.RegBits(RegBits)) u_merge (
        .old_i   (old_word),
        .wdata_i (cur_wdata),
        .type_i  (cur_type),
        .off_i   (cur_addr[1:0]),
        .merged_o(merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                state_d = WaitCycles == 0 ? ST_RESP : ST_WAIT;
                cnt_d   = WaitCycles == 0 ? 4'd0 : 4'(WaitCycles - 1);
            end
            ST_WAIT: begin
                state_d = cnt_q == 4'd0 ? ST_RESP : ST_WAIT;
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            end
            ST_RESP: state_d = rsp_ready_i ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= we_i;
            end
            if (enter_resp) begin
                rdata_q <= commit ? merged : old_word;
                err_q   <= misaligned || out_of_range;
            end else if (state_q == ST_RESP && rsp_ready_i) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit) mem[idx] <= merged;
    end

    assign req_ready_o = state_q == ST_IDLE;
    assign rsp_valid_o = state_q == ST_RESP;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule
